// File: rtl/po2_pkg.sv
// Shared types and default widths for the power-of-two accumulator datapath.
package po2_pkg;

  typedef enum logic [1:0] {ACCUM, BIAS, CLIP, EMIT} po2_acc_state_t;

  localparam int PO2_W = 16;
  localparam int PO2_I = 4;

endpackage

// File: rtl/po2_saturate.sv
// Combinational clip of a wide signed accumulator to W bits, followed by an optional ReLU clamp.
module po2_saturate #(
  parameter int IN_W = 20,
  parameter int W    = 16
) (
  input  logic signed [IN_W-1:0] acc,
  input  logic                   relu_en,
  output logic signed [W-1:0]    result
);

  localparam logic signed [IN_W-1:0] MAX_V = {{(IN_W-W+1){1'b0}}, {(W-1){1'b1}}};
  localparam logic signed [IN_W-1:0] MIN_V = ~MAX_V;

  function automatic logic signed [W-1:0] sat(input logic signed [IN_W-1:0] v);
    if (v > MAX_V)      sat = MAX_V[W-1:0];
    else if (v < MIN_V) sat = MIN_V[W-1:0];
    else                sat = v[W-1:0];
  endfunction

  function automatic logic signed [W-1:0] relu(input logic signed [W-1:0] v, input logic en);
    relu = (en && v[W-1]) ? '0 : v;
  endfunction

  assign result = relu(sat(acc), relu_en);

endmodule

// File: rtl/po2_accumulator.sv
// Sums K signed products plus a bias, saturates to W bits, optionally applies ReLU,
// and hands one activation downstream per row over valid/ready.
module po2_accumulator
  import po2_pkg::*;
#(
  parameter int W     = PO2_W,
  parameter int I     = PO2_I,
  parameter int K     = 4,
  parameter int ACC_W = W + $clog2(K + 1) + 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic signed [W-1:0] in_data,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic signed [W-1:0] bias,
  input  logic                relu_en,
  output logic signed [W-1:0] out_data,
  output logic                out_valid,
  input  logic                out_ready
);

  localparam int               CNT_W    = (K > 1) ? $clog2(K) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(K - 1);

  generate
    if (K < 1 || I < 1 || I > W || ACC_W <= W) begin : g_bad_params
      $error("po2_accumulator: illegal parameter combination");
    end
  endgenerate

  function automatic logic signed [ACC_W-1:0] sext(input logic signed [W-1:0] v);
    return {{(ACC_W-W){v[W-1]}}, v};
  endfunction

  po2_acc_state_t          state;
  logic [CNT_W-1:0]        cnt;
  logic signed [ACC_W-1:0] acc;
  logic signed [W-1:0]     sat_r;

  po2_saturate #(
    .IN_W (ACC_W),
    .W    (W)
  ) u_sat (
    .acc     (acc),
    .relu_en (relu_en),
    .result  (sat_r)
  );

  assign in_ready = (state == ACCUM);

  // Row sequencing: accumulate K terms, add bias, clip into the output register, hold until taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ACCUM;
      cnt       <= '0;
      acc       <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        ACCUM: begin
          if (in_valid) begin
            acc <= acc + sext(in_data);
            if (cnt == CNT_LAST) begin
              cnt   <= '0;
              state <= BIAS;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
        end
        BIAS: begin
          acc   <= acc + sext(bias);
          state <= CLIP;
        end
        CLIP: begin
          out_data  <= sat_r;
          out_valid <= 1'b1;
          state     <= EMIT;
        end
        EMIT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            acc       <= '0;
            state     <= ACCUM;
          end
        end
        default: state <= ACCUM;
      endcase
    end
  end

endmodule

// File: tb/tb_po2_accumulator.sv
// Bench for po2_accumulator: directed rows with literal results plus randomized rows against a cycle model.
`timescale 1ns/1ps
module tb_po2_accumulator;

  localparam int W = 16;
  localparam int K = 4;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic signed [W-1:0] in_data = '0;
  logic                in_valid = 1'b0;
  logic                in_ready;
  logic signed [W-1:0] bias = '0;
  logic                relu_en = 1'b0;
  logic signed [W-1:0] out_data;
  logic                out_valid;
  logic                out_ready = 1'b1;

  int total = 0;
  int passed = 0;
  bit rnd_mode = 1'b0;

  logic signed [W-1:0] t1  [K] = '{16'h1000, 16'h0800, 16'hF000, 16'h0400};
  logic signed [W-1:0] t2a [K] = '{16'h7000, 16'h7000, 16'h7000, 16'h7000};
  logic signed [W-1:0] t2b [K] = '{16'h8000, 16'h8000, 16'h8000, 16'h8000};
  logic signed [W-1:0] t3  [K] = '{16'hF800, 16'h0000, 16'h0000, 16'h0000};

  po2_accumulator #(.W(W), .K(K)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .bias      (bias),
    .relu_en   (relu_en),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input longint act, input longint req);
    total++;
    if (act == req) passed++;
    else $display("FAIL %s: got %0d, required %0d", name, act, req);
  endtask

  // Reference: a row is the plain integer sum of K accepted terms plus the bias seen
  // one cycle later, clamped to the W-bit range and ReLU'd with relu_en seen one cycle after that.
  function automatic logic signed [W-1:0] clip_relu(input longint s, input bit relu);
    longint r;
    r = s;
    if (r > 32767) r = 32767;
    if (r < -32768) r = -32768;
    if (relu && r < 0) r = 0;
    return W'(r);
  endfunction

  int                  m_phase = 0;
  int                  m_cnt = 0;
  longint              m_acc = 0;
  logic signed [W-1:0] m_data = '0;
  bit                  m_valid = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase = 0;
      m_cnt   = 0;
      m_acc   = 0;
      m_data  = '0;
      m_valid = 1'b0;
    end else begin
      case (m_phase)
        0: if (in_valid) begin
          m_acc += in_data;
          m_cnt++;
          if (m_cnt == K) begin
            m_cnt   = 0;
            m_phase = 1;
          end
        end
        1: begin
          m_acc += bias;
          m_phase = 2;
        end
        2: begin
          m_data  = clip_relu(m_acc, relu_en);
          m_valid = 1'b1;
          m_phase = 3;
        end
        default: if (out_ready) begin
          m_valid = 1'b0;
          m_acc   = 0;
          m_phase = 0;
        end
      endcase
      #1;
      if (rst_n) begin
        check("model_in_ready", in_ready, (m_phase == 0) ? 1 : 0);
        check("model_out_valid", out_valid, m_valid);
        check("model_out_data", out_data, m_data);
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    if (rnd_mode) begin
      bias      = W'($urandom);
      relu_en   = 1'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
    end
  endtask

  task automatic send_term(input logic signed [W-1:0] v, input int gap);
    int n;
    n = 0;
    in_valid = 1'b0;
    repeat (gap) tick();
    in_data  = v;
    in_valid = 1'b1;
    while (!in_ready && n < 200) begin
      tick();
      n++;
    end
    check("accept_timeout", in_ready, 1);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic send_row(input logic signed [W-1:0] row [K], input int gmax);
    for (int i = 0; i < K; i++)
      send_term(row[i], (gmax == 0) ? 0 : int'($urandom_range(1, gmax)));
  endtask

  task automatic get_result(input string name, output logic signed [W-1:0] d);
    int n;
    n = 0;
    while (!out_valid && n < 100) begin
      tick();
      n++;
    end
    check({name, "_valid"}, out_valid, 1);
    d = out_data;
    tick();
  endtask

  task automatic run_row(input string name, input logic signed [W-1:0] row [K],
                         input logic signed [W-1:0] b, input logic relu,
                         input int gmax, input logic signed [W-1:0] expd);
    logic signed [W-1:0] d;
    bias    = b;
    relu_en = relu;
    send_row(row, gmax);
    get_result(name, d);
    check(name, d, expd);
  endtask

  initial begin
    logic signed [W-1:0] held;
    logic signed [W-1:0] v;
    int sel;

    repeat (3) tick();
    check("reset_out_valid", out_valid, 0);
    rst_n = 1'b1;
    tick();
    check("reset_out_data", out_data, 0);
    check("reset_in_ready", in_ready, 1);

    // Basic row with explicit latency
    bias = 16'h0200;
    relu_en = 1'b0;
    send_row(t1, 0);
    @(posedge clk); #1;
    check("latency_edge1", out_valid, 0);
    @(posedge clk); #1;
    check("latency_edge2", out_valid, 1);
    check("basic", out_data, 16'h0E00);
    tick();
    tick();

    run_row("sat_pos", t2a, 16'h0000, 1'b0, 0, 16'h7FFF);
    run_row("sat_neg", t2b, 16'h8000, 1'b0, 0, 16'h8000);
    run_row("relu_on", t3, 16'h0000, 1'b1, 0, 16'h0000);
    run_row("relu_off", t3, 16'h0000, 1'b0, 0, 16'hF800);

    // Backpressure with stray input pulses
    out_ready = 1'b0;
    bias = 16'h0200;
    relu_en = 1'b0;
    send_row(t1, 0);
    get_result("bp", held);
    check("bp_value", held, 16'h0E00);
    for (int i = 0; i < 5; i++) begin
      in_data  = 16'h7FFF;
      in_valid = 1'b1;
      tick();
      check("bp_hold_data", out_data, held);
      check("bp_hold_valid", out_valid, 1);
      check("bp_in_ready", in_ready, 0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    check("bp_ready_after", in_ready, 1);
    run_row("bp_next_row", t1, 16'h0200, 1'b0, 0, 16'h0E00);

    run_row("gaps", t1, 16'h0200, 1'b0, 3, 16'h0E00);

    // Reset with a pending output, then reset with a partial row
    out_ready = 1'b0;
    send_row(t1, 0);
    get_result("pre_reset", held);
    rst_n = 1'b0;
    #1;
    check("reset_drops_valid", out_valid, 0);
    check("reset_drops_data", out_data, 0);
    tick();
    rst_n = 1'b1;
    out_ready = 1'b1;
    tick();
    send_term(16'h1000, 0);
    send_term(16'h1000, 0);
    rst_n = 1'b0;
    #1;
    check("midrow_reset_valid", out_valid, 0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    run_row("after_reset", t1, 16'h0200, 1'b0, 0, 16'h0E00);

    // Randomized rows: bias, relu_en and out_ready churn every cycle
    rnd_mode = 1'b1;
    for (int r = 0; r < 150; r++) begin
      for (int i = 0; i < K; i++) begin
        sel = int'($urandom_range(0, 2));
        if (sel == 0)      v = W'($urandom);
        else if (sel == 1) v = W'($urandom_range(0, 16'h1FFF)) - 16'sh1000;
        else               v = $urandom_range(0, 1) ? 16'sh7FFF : 16'sh8000;
        send_term(v, int'($urandom_range(0, 2)));
      end
    end
    rnd_mode = 1'b0;
    out_ready = 1'b1;
    repeat (12) tick();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

endmodule
